l3c_fifo_pop_ctrl: RTL and testbench
====================================

L3C_FIFO_POP_CTRL -- requirements
Module: l3c_fifo_pop_ctrl

Interface
REQ-001 Parameter NUM_FIFO, default 32: number of FIFO lanes served.
REQ-002 Parameter CNT_W, default 32: pop-count width per lane.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 need_pop_matrix_i  input  NUM_FIFO  per-lane command bit; any nonzero value is a one-cycle command.
REQ-006 pop_num_matrix_i  input  NUM_FIFO x CNT_W (unpacked array)  per-lane pop count; sampled only in a command cycle.
REQ-007 fifo_empty_i  input  NUM_FIFO  per-lane FIFO empty flag.
REQ-008 fifo_pop_o  output  NUM_FIFO  per-lane pop strobe; one pop per asserted cycle.
REQ-009 fifo_done_matrix_o  output  NUM_FIFO  per-lane completion, level.
REQ-010 busy_o  output  1  high while any lane is active.
REQ-011 cmd_err_o  output  1  one-cycle pulse when a command is dropped.

Function
REQ-012 Per lane: registers active (1b), remaining (CNT_W), done (1b).
REQ-013 Command accept: need_pop_matrix_i != 0 and busy_o == 0; the accept updates all lanes on the next edge.
REQ-014 On accept, a lane with need bit 1 and pop_num != 0 SHALL load remaining = pop_num, set active = 1, and clear done.
REQ-015 On accept, a lane with need bit 1 and pop_num == 0 SHALL set done = 1 and keep active = 0.
REQ-016 On accept, a lane with need bit 0 SHALL set done = 1 and active = 0, because it has nothing to pop.
REQ-017 fifo_pop_o[k] = active[k] & (remaining[k] != 0) & ~fifo_empty_i[k]; the term is combinational from registers and the empty flag.
REQ-018 fifo_pop_o is never asserted in the accept cycle; the first pop can occur 1 cycle after accept.
REQ-019 Each cycle with fifo_pop_o[k] = 1 SHALL decrement remaining[k] by 1.
REQ-020 When remaining[k] == 1 and a pop occurs, the next edge SHALL set remaining = 0, active = 0 and done = 1.
REQ-021 With no stalls, done[k] rises N+1 cycles after accept for pop_num = N.
REQ-022 While empty is high, the lane stalls: no pop, no decrement, state held.
REQ-023 Done bits are held until the next accepted command.
REQ-024 busy_o = OR of active bits, registered state only.
REQ-025 Command while busy_o == 1: the command is ignored, no lane state changes, and cmd_err_o pulses for exactly 1 cycle.
REQ-026 Command arriving in the same cycle as the final pop: busy_o is still 1, so the command is dropped and cmd_err_o pulses.
REQ-027 Lanes run independently; a stalled lane never blocks pops on other lanes.
REQ-028 remaining never wraps; a decrement is impossible at 0 by REQ-017.

Reset
REQ-029 rst_n low SHALL asynchronously clear every lane: active = 0, remaining = 0, done = 0.
REQ-030 Reset values of outputs: fifo_pop_o = 0, fifo_done_matrix_o = 0, busy_o = 0, cmd_err_o = 0.
REQ-031 Reset mid-operation SHALL abandon the outstanding counts; pops stop in the same cycle reset is asserted.
REQ-032 After reset release, the block is idle and accepts the next command.

Structure
REQ-033 Package l3c_pkg holds NUM_FIFO, CNT_W and a lane-count typedef; the L2C controllers import the same package.
REQ-034 One sub-module, l3c_pop_lane, implements the REQ-012..REQ-022 lane logic; it is instantiated NUM_FIFO times in a generate loop.
REQ-035 The top level holds only the accept decode, busy_o and cmd_err_o.

Verification
REQ-036 Scenario 1: all need bits = 1, pop_num = 1, empty = 0 -> each fifo_pop_o pulses once on cycle 1 after accept; done = 32'hFFFF_FFFF on cycle 2; busy_o low on cycle 2.
REQ-037 Scenario 2: lane 3 pop_num = 5, empty held high on cycles 2-4 -> exactly 5 pops on lane 3, none while empty is high; done[3] rises 9 cycles after accept.
REQ-038 Scenario 3: need = 32'h0000_00F0, pop_num = 2 on those lanes -> lanes 4-7 pop twice each; other lanes show done = 1 on cycle 1 with zero pops.
REQ-039 Scenario 4: pop_num = 0 with need = 1 on lane 0 -> done[0] = 1 on cycle 1, fifo_pop_o[0] never asserts, busy_o stays 0 if all lanes are zero.
REQ-040 Scenario 5: second command issued while lane 1 still has 3 pops left -> cmd_err_o pulses 1 cycle; lane 1 completes its original 3 pops; done is unchanged by the dropped command.
REQ-041 Scenario 6: rst_n pulsed low mid-count (lane 2 remaining = 4) -> all outputs 0 immediately; a new command after release runs normally.

Source files
------------

// File: rtl/l3c_pkg.sv
// Shared L3C sizing constants and lane-count type.
//   NUM_FIFO   : default number of FIFO lanes served by a pop controller
//   CNT_W      : default pop-count width per lane
//   lane_cnt_t : one lane's pop count
package l3c_pkg;

  localparam int unsigned NUM_FIFO = 32;
  localparam int unsigned CNT_W    = 32;

  typedef logic [CNT_W-1:0] lane_cnt_t;

endpackage : l3c_pkg

// File: rtl/l3c_pop_lane.sv
// One FIFO lane of the pop controller: loads a pop count on an accepted
// command, then issues one pop per cycle whenever the FIFO is not empty.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   accept        : command accepted this cycle (common to all lanes)
//   need          : this lane's command bit
//   pop_num       : this lane's pop count, used only with accept
//   fifo_empty    : lane FIFO empty flag (stalls the lane)
//   fifo_pop      : pop strobe, combinational from state and fifo_empty
//   done          : completion level, held until the next accept
//   active        : lane still has pops outstanding
module l3c_pop_lane #(
  parameter int unsigned CNT_W = l3c_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             need,
  input  logic [CNT_W-1:0] pop_num,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  output logic             done,
  output logic             active
);

  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // Pop only while counting and data is available; never at remaining == 0.
  assign fifo_pop = active_q & (remaining_q != '0) & ~fifo_empty;
  assign done     = done_q;
  assign active   = active_q;

  // Next-state: accept reloads the lane, otherwise each pop consumes one count.
  always_comb begin
    remaining_d = remaining_q;
    active_d    = active_q;
    done_d      = done_q;
    if (accept) begin
      if (need && (pop_num != '0)) begin
        remaining_d = pop_num;
        active_d    = 1'b1;
        done_d      = 1'b0;
      end else begin
        // Nothing to pop on this lane: complete immediately.
        remaining_d = '0;
        active_d    = 1'b0;
        done_d      = 1'b1;
      end
    end else if (fifo_pop) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

endmodule : l3c_pop_lane

// File: rtl/l3c_fifo_pop_ctrl.sv
// Multi-lane FIFO pop controller. A nonzero need vector while idle starts
// every lane at once; commands arriving while busy are dropped and flagged.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   need_pop_matrix_i   : per-lane command bits (nonzero = one-cycle command)
//   pop_num_matrix_i    : per-lane pop counts, sampled on accept
//   fifo_empty_i        : per-lane FIFO empty flags
//   fifo_pop_o          : per-lane pop strobes
//   fifo_done_matrix_o  : per-lane completion levels
//   busy_o              : any lane still active
//   cmd_err_o           : one-cycle pulse after a dropped command
module l3c_fifo_pop_ctrl #(
  parameter int unsigned NUM_FIFO = l3c_pkg::NUM_FIFO,
  parameter int unsigned CNT_W    = l3c_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_FIFO-1:0] need_pop_matrix_i,
  input  logic [CNT_W-1:0]    pop_num_matrix_i [NUM_FIFO],
  input  logic [NUM_FIFO-1:0] fifo_empty_i,
  output logic [NUM_FIFO-1:0] fifo_pop_o,
  output logic [NUM_FIFO-1:0] fifo_done_matrix_o,
  output logic                busy_o,
  output logic                cmd_err_o
);

  logic [NUM_FIFO-1:0] active;
  logic                cmd_any;
  logic                accept;
  logic                drop;
  logic                cmd_err_q;

  // Accept decode; busy_o comes only from registered lane state.
  assign cmd_any   = |need_pop_matrix_i;
  assign busy_o    = |active;
  assign accept    = cmd_any & ~busy_o;
  assign drop      = cmd_any & busy_o;
  assign cmd_err_o = cmd_err_q;

  // Dropped-command flag, one cycle after the offending command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= drop;
    end
  end

  // One independent lane per FIFO.
  for (genvar k = 0; k < NUM_FIFO; k++) begin : g_lane
    l3c_pop_lane #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (accept),
      .need       (need_pop_matrix_i[k]),
      .pop_num    (pop_num_matrix_i[k]),
      .fifo_empty (fifo_empty_i[k]),
      .fifo_pop   (fifo_pop_o[k]),
      .done       (fifo_done_matrix_o[k]),
      .active     (active[k])
    );
  end

endmodule : l3c_fifo_pop_ctrl

// File: tb/tb_l3c_fifo_pop_ctrl.sv
// Directed bench for l3c_fifo_pop_ctrl. Cycle 0 is the cycle the command is
// driven; inputs change and outputs are sampled just after the rising edge.
module tb_l3c_fifo_pop_ctrl;
  import l3c_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [NUM_FIFO-1:0] need;
  lane_cnt_t           pop_num [NUM_FIFO];
  logic [NUM_FIFO-1:0] empty;
  logic [NUM_FIFO-1:0] pop;
  logic [NUM_FIFO-1:0] done;
  logic                busy;
  logic                cmd_err;

  int n_checks;
  int n_fail;

  l3c_fifo_pop_ctrl #(
    .NUM_FIFO (NUM_FIFO),
    .CNT_W    (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .need_pop_matrix_i  (need),
    .pop_num_matrix_i   (pop_num),
    .fifo_empty_i       (empty),
    .fifo_pop_o         (pop),
    .fifo_done_matrix_o (done),
    .busy_o             (busy),
    .cmd_err_o          (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pop_all(input lane_cnt_t v);
    for (int i = 0; i < NUM_FIFO; i++) pop_num[i] = v;
  endtask

  int pops_a, pops_b, bad_pops, done_a_cyc, done_b_cyc, other_pops;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    need     = '0;
    empty    = '0;
    set_pop_all('0);

    // Reset state
    tick();
    tick();
    check("rst_pop", pop, 32'h0);
    check("rst_done", done, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(cmd_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: every lane pops once
    need = '1;
    set_pop_all(1);
    #1;
    check("s1_c0_pop", pop, 32'h0);
    check("s1_c0_busy", 32'(busy), 32'h0);
    tick();
    need = '0;
    #1;
    check("s1_c1_pop", pop, 32'hFFFF_FFFF);
    check("s1_c1_busy", 32'(busy), 32'h1);
    check("s1_c1_done", done, 32'h0);
    tick();
    check("s1_c2_pop", pop, 32'h0);
    check("s1_c2_done", done, 32'hFFFF_FFFF);
    check("s1_c2_busy", 32'(busy), 32'h0);

    // Scenario 2: lane 3 stalls on cycles 2-4, lane 10 runs unstalled
    set_pop_all(0);
    pop_num[3]  = 5;
    pop_num[10] = 3;
    need        = (32'h1 << 3) | (32'h1 << 10);
    pops_a = 0; pops_b = 0; bad_pops = 0; done_a_cyc = -1; done_b_cyc = -1;
    tick();
    need = '0;
    #1;
    check("s2_c1_done", done, 32'hFFFF_FBF7);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      empty = (c >= 2 && c <= 4) ? (32'h1 << 3) : 32'h0;
      #1;
      if (pop[3]) pops_a++;
      if (pop[10]) pops_b++;
      if (pop[3] && empty[3]) bad_pops++;
      if (done[3] && done_a_cyc < 0) done_a_cyc = c;
      if (done[10] && done_b_cyc < 0) done_b_cyc = c;
    end
    empty = '0;
    check("s2_pops_l3", 32'(pops_a), 32'd5);
    check("s2_pops_l10", 32'(pops_b), 32'd3);
    check("s2_pop_while_empty", 32'(bad_pops), 32'd0);
    check("s2_done_l3_cycle", 32'(done_a_cyc), 32'd9);
    check("s2_done_l10_cycle", 32'(done_b_cyc), 32'd4);
    check("s2_end_busy", 32'(busy), 32'h0);

    // Scenario 3: lanes 4-7 pop twice, others ignore their counts
    set_pop_all(7);
    for (int i = 4; i <= 7; i++) pop_num[i] = 2;
    need = 32'h0000_00F0;
    tick();
    need = '0;
    #1;
    check("s3_c1_done", done, 32'hFFFF_FF0F);
    check("s3_c1_pop", pop, 32'h0000_00F0);
    tick();
    check("s3_c2_pop", pop, 32'h0000_00F0);
    tick();
    check("s3_c3_pop", pop, 32'h0);
    check("s3_c3_done", done, 32'hFFFF_FFFF);
    check("s3_c3_busy", 32'(busy), 32'h0);

    // Scenario 4: zero count completes at once without popping
    set_pop_all(0);
    need = 32'h1;
    tick();
    need = '0;
    #1;
    check("s4_c1_done", done, 32'hFFFF_FFFF);
    check("s4_c1_busy", 32'(busy), 32'h0);
    check("s4_c1_pop", pop, 32'h0);
    tick();
    check("s4_c2_pop", pop, 32'h0);

    // Scenario 5: commands while busy, including one on the final pop
    set_pop_all(0);
    pop_num[1] = 4;
    need = 32'h2;
    pops_a = 0; other_pops = 0;
    tick();
    need = '0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      need = '0;
      if (c == 2) begin need = '1; set_pop_all(9); end
      if (c == 4) need = 32'h1;
      #1;
      if (pop[1]) pops_a++;
      if ((pop & ~32'h2) != 0) other_pops++;
      if (c == 2) check("s5_c2_err", 32'(cmd_err), 32'h0);
      if (c == 3) begin
        check("s5_c3_err", 32'(cmd_err), 32'h1);
        check("s5_c3_done", done, 32'hFFFF_FFFD);
        check("s5_c3_busy", 32'(busy), 32'h1);
      end
      if (c == 4) check("s5_c4_err", 32'(cmd_err), 32'h0);
      if (c == 5) begin
        check("s5_c5_err", 32'(cmd_err), 32'h1);
        check("s5_c5_done", done, 32'hFFFF_FFFF);
        check("s5_c5_busy", 32'(busy), 32'h0);
      end
      if (c == 6) begin
        check("s5_c6_err", 32'(cmd_err), 32'h0);
        check("s5_c6_done", done, 32'hFFFF_FFFF);
      end
    end
    need = '0;
    check("s5_pops_l1", 32'(pops_a), 32'd4);
    check("s5_other_pops", 32'(other_pops), 32'd0);

    // Scenario 6: reset mid-count, then a fresh command
    set_pop_all(0);
    pop_num[2] = 6;
    need = 32'h4;
    tick();
    need = '0;
    #1;
    check("s6_c1_pop", pop, 32'h4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("s6_rst_pop", pop, 32'h0);
    check("s6_rst_done", done, 32'h0);
    check("s6_rst_busy", 32'(busy), 32'h0);
    check("s6_rst_err", 32'(cmd_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s6_idle_pop", pop, 32'h0);
    pop_num[2] = 2;
    need = 32'h4;
    tick();
    need = '0;
    #1;
    check("s6_new_c1_done", done, 32'hFFFF_FFFB);
    check("s6_new_c1_pop", pop, 32'h4);
    tick();
    check("s6_new_c2_pop", pop, 32'h4);
    tick();
    check("s6_new_c3_done", done, 32'hFFFF_FFFF);
    check("s6_new_c3_busy", 32'(busy), 32'h0);
    check("s6_new_c3_pop", pop, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of sequence, want completion before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_l3c_fifo_pop_ctrl
